rw_mem_responder: RTL

RW_MEM_RESPONDER -- requirements
Module: rw_mem_responder

---
 rtl/rw_mem_responder.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/rw_mem_responder.sv
// rtl/rw_mem_responder.sv - single-port word store with posted write buffer and aligned read bursts
module rw_mem_responder #(
  parameter int DEPTH_WORDS  = 4096,
  parameter int READ_LATENCY = 2,
  parameter int WB_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        request,
  input  logic [29:0] addr,
  input  logic        rnw,
  input  logic        rmw,
  input  logic [4:0]  rlen,
  input  logic [3:0]  wbe,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        write_outstanding
);

  localparam int AW  = $clog2(DEPTH_WORDS);
  localparam int WAW = $clog2(WB_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

  state_t         state;
  logic [3:0]     lat_cnt;
  logic [4:0]     cnt;
  logic [AW-1:0]  ptr;

  logic [31:0]    mem [DEPTH_WORDS];

  logic [AW-1:0]  wb_addr [WB_DEPTH];
  logic [3:0]     wb_be   [WB_DEPTH];
  logic [31:0]    wb_data [WB_DEPTH];
  logic [WAW-1:0] head;
  logic [WAW-1:0] tail;
  logic [WAW:0]   occ;

  logic           full;
  logic           empty;
  logic           rd_accept;
  logic           wr_accept;
  logic           enter_burst;
  logic           burst_more;
  logic           issue;
  logic           pop;
  logic [AW-1:0]  base;
  logic [AW-1:0]  rd_idx;
  logic           unused;

  assign unused = ^{rmw, addr[29:AW]};

  // full/empty come from registered occupancy, so ack never depends on addr/wdata/wbe
  assign full  = (occ == (WAW+1)'(WB_DEPTH));
  assign empty = (occ == '0);

  assign rd_accept = request & rnw & (state == IDLE) & empty & ~rst;
  assign wr_accept = request & ~rnw & ~full & ~rst;
  assign ack       = rd_accept | wr_accept;

  assign base = addr[AW-1:0] & ~AW'(rlen);

  // A word is fetched on the edge entering BURST and on every BURST edge but the last,
  // so rvalid is high exactly while the engine sits in BURST.
  assign enter_burst = ((state == WAIT) && (lat_cnt == '0)) ||
                       (rd_accept && (READ_LATENCY == 1));
  assign burst_more  = (state == BURST) && (cnt != '0);
  assign issue       = enter_burst | burst_more;
  assign rd_idx      = (state == IDLE) ? base : ptr;

  assign pop = ~empty & ~rst & (state != BURST) & ~enter_burst;

  assign write_outstanding = ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      lat_cnt <= '0;
      cnt     <= '0;
      ptr     <= '0;
      rvalid  <= 1'b0;
      rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_accept) begin
            cnt <= rlen;
            ptr <= base;
            if (READ_LATENCY == 1) begin
              state <= BURST;
            end else begin
              state   <= WAIT;
              lat_cnt <= 4'(READ_LATENCY - 2);
            end
          end
        end
        WAIT: begin
          if (lat_cnt == '0) state <= BURST;
          else               lat_cnt <= lat_cnt - 4'd1;
        end
        BURST: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - 5'd1;
        end
        default: state <= IDLE;
      endcase
      rvalid <= issue;
      if (issue) begin
        rdata <= mem[rd_idx];
        ptr   <= rd_idx + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      if (wr_accept) tail <= tail + WAW'(1);
      if (pop)       head <= head + WAW'(1);
      occ <= occ + (WAW+1)'(wr_accept) - (WAW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      wb_addr[tail] <= addr[AW-1:0];
      wb_be[tail]   <= wbe;
      wb_data[tail] <= wdata;
    end
  end

  // Only enabled bytes are committed; a wbe=0 entry is simply retired
  always_ff @(posedge clk) begin
    if (pop) begin
      for (int i = 0; i < 4; i++) begin
        if (wb_be[head][i]) mem[wb_addr[head]][8*i +: 8] <= wb_data[head][8*i +: 8];
      end
    end
  end

endmodule
